// File: rtl/mulfunc_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier.
package mulfunc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int unsigned calc_n(input int unsigned xlen, input int unsigned bpc);
        return xlen / bpc;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned shift_w(input int unsigned xlen);
        return $clog2(2 * xlen);
    endfunction

endpackage

// File: rtl/mulfunc_if.sv
// Request/acknowledge bus of the multiplier: operands in, product out.
interface mulfunc_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            sgn;
    logic            vld;
    logic            rdy;
    logic [XLEN-1:0] prod_lo;
    logic [XLEN-1:0] prod_hi;
    logic            ack;

    modport master (
        output a, b, sgn, vld,
        input  rdy, prod_lo, prod_hi, ack
    );

    modport slave (
        input  a, b, sgn, vld,
        output rdy, prod_lo, prod_hi, ack
    );
endinterface

// File: rtl/mulfunc_step.sv
// One shift-add iteration: adds a * b-slice, shifted into place, to the accumulator.
module mulfunc_step
    import mulfunc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 4,
    parameter int unsigned SHW  = 6
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   a,
    input  logic [BPC-1:0]    bs,
    input  logic [SHW-1:0]    shift,
    output logic [2*XLEN-1:0] acc_nx
);
    logic [2*XLEN-1:0] pp;

    assign pp     = {{XLEN{1'b0}}, a} * {{(2*XLEN-BPC){1'b0}}, bs};
    assign acc_nx = acc + (pp << shift);
endmodule

// File: rtl/mulfunc_seq.sv
// Iterative multiplier, BPC multiplier bits per cycle, single-pulse vld/ack.
// Optional two's-complement support via `define MULFUNC_SIGNED_EN.
module mulfunc_seq
    import mulfunc_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPC  = 4
) (
    input  logic      clk,
    input  logic      rst,
    mulfunc_if.slave  bus
);
    localparam int unsigned N   = calc_n(XLEN, BPC);
    localparam int unsigned CW  = cnt_w(N);
    localparam int unsigned SHW = shift_w(XLEN);

    if (XLEN % BPC != 0) begin : g_chk
        $error("mulfunc_seq: XLEN must be a multiple of BPC");
    end

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   a_r, b_r;
    logic [XLEN-1:0]   a_in, b_in;
    logic [2*XLEN-1:0] acc, acc_nx, res;
    logic [SHW-1:0]    shift;
    logic              accept, last;

    assign shift = SHW'(cnt) * SHW'(BPC);

    mulfunc_step #(
        .XLEN (XLEN),
        .BPC  (BPC),
        .SHW  (SHW)
    ) u_step (
        .acc    (acc),
        .a      (a_r),
        .bs     (b_r[BPC-1:0]),
        .shift  (shift),
        .acc_nx (acc_nx)
    );

`ifdef MULFUNC_SIGNED_EN
    // Operands are latched as magnitudes; the sign is re-applied on the final load.
    logic neg, neg_in;

    always_comb begin
        neg_in = bus.sgn & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
        a_in   = (bus.sgn & bus.a[XLEN-1]) ? -bus.a : bus.a;
        b_in   = (bus.sgn & bus.b[XLEN-1]) ? -bus.b : bus.b;
        res    = neg ? -acc_nx : acc_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            neg <= 1'b0;
        else if (accept)
            neg <= neg_in;
    end
`else
    logic unused_sgn;

    assign unused_sgn = bus.sgn;
    assign a_in       = bus.a;
    assign b_in       = bus.b;
    assign res        = acc_nx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.vld) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (cnt == CW'(N - 1)) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.rdy = (state == IDLE);
    assign bus.ack = (state == DONE);

    // The product registers load on the final RUN edge so they are valid throughout DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            cnt         <= '0;
            bus.prod_lo <= '0;
            bus.prod_hi <= '0;
        end else if (accept) begin
            a_r <= a_in;
            b_r <= b_in;
            acc <= '0;
            cnt <= '0;
        end else if (state == RUN) begin
            acc <= acc_nx;
            b_r <= b_r >> BPC;
            cnt <= cnt + CW'(1);
            if (last) begin
                bus.prod_lo <= res[XLEN-1:0];
                bus.prod_hi <= res[2*XLEN-1:XLEN];
            end
        end
    end
endmodule

// File: tb/tb_mulfunc_seq.sv
// Directed and random checks of mulfunc_seq (XLEN=32, BPC=4).
module tb_mulfunc_seq;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    mulfunc_if #(.XLEN(32)) bus ();

    mulfunc_seq #(
        .XLEN (32),
        .BPC  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle 1 is the cycle right after the accepting edge; returns the cycle in which ack is seen.
    task automatic do_op(input logic [31:0] ia, input logic [31:0] ib, input logic isgn,
                         output logic [63:0] p, output int cyc);
        int guard;
        guard = 0;
        while (!bus.rdy && guard < 50) begin
            tick();
            guard++;
        end
        bus.a   = ia;
        bus.b   = ib;
        bus.sgn = isgn;
        bus.vld = 1'b1;
        tick();
        bus.vld = 1'b0;
        cyc = 1;
        while (!bus.ack && cyc < 40) begin
            tick();
            cyc++;
        end
        p = {bus.prod_hi, bus.prod_lo};
    endtask

    logic [63:0] p, p1, p2, exp64;
    logic [31:0] ra, rb;
    int          cyc, nacks, ackcyc, ack1, ack2;
    logic        bad;

    initial begin
        rst     = 1'b1;
        bus.a   = '0;
        bus.b   = '0;
        bus.sgn = 1'b0;
        bus.vld = 1'b0;

        // Reset
        tick();
        chk("rst_rdy", 64'(bus.rdy), 64'd1);
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
        rst = 1'b0;
        tick();

        // Full-range unsigned
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, cyc);
        chk("max_lat", 64'(cyc), 64'd9);
        chk("max_prod", p, 64'hFFFF_FFFE_0000_0001);
        tick();
        chk("max_ack_pulse", 64'(bus.ack), 64'd0);
        tick();
        chk("max_hold", {bus.prod_hi, bus.prod_lo}, 64'hFFFF_FFFE_0000_0001);

        // Busy rejection
        bus.a = 32'd7; bus.b = 32'd6; bus.vld = 1'b1;
        tick();
        bus.vld = 1'b0;
        nacks = 0; ackcyc = 0; bad = 1'b0; p = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 2) begin bus.a = 32'd3; bus.b = 32'd3; bus.vld = 1'b1; end
            if (c == 3) bus.vld = 1'b0;
            if (c <= 9 && bus.rdy) bad = 1'b1;
            if (bus.ack) begin
                nacks++;
                ackcyc = c;
                p = {bus.prod_hi, bus.prod_lo};
            end
            tick();
        end
        chk("busy_nacks", 64'(nacks), 64'd1);
        chk("busy_lat", 64'(ackcyc), 64'd9);
        chk("busy_prod", p, 64'd42);
        chk("busy_rdy_low", 64'(bad), 64'd0);

        // Abort mid-operation
        bus.a = 32'd100; bus.b = 32'd100; bus.vld = 1'b1;
        tick();
        bus.vld = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
        chk("abort_rdy", 64'(bus.rdy), 64'd1);
        tick();
        rst = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (bus.ack) bad = 1'b1;
            tick();
        end
        chk("abort_no_ack", 64'(bad), 64'd0);
        do_op(32'd2, 32'd3, 1'b0, p, cyc);
        chk("abort_next_prod", p, 64'd6);
        tick();

        // Back-to-back with vld held high
        bus.a = 32'd5; bus.b = 32'd9; bus.vld = 1'b1;
        tick();
        bus.a = 32'd0; bus.b = 32'd12345;
        ack1 = 0; ack2 = 0; p1 = '1; p2 = '1;
        for (int c = 1; c <= 30; c++) begin
            if (bus.ack) begin
                if (ack1 == 0) begin
                    ack1 = c;
                    p1 = {bus.prod_hi, bus.prod_lo};
                end else if (ack2 == 0) begin
                    ack2 = c;
                    p2 = {bus.prod_hi, bus.prod_lo};
                    bus.vld = 1'b0;
                end
            end
            tick();
        end
        bus.vld = 1'b0;
        chk("b2b_ack1", 64'(ack1), 64'd9);
        chk("b2b_ack2", 64'(ack2), 64'd19);
        chk("b2b_prod1", p1, 64'd45);
        chk("b2b_prod2", p2, 64'd0);

        // Signed request (expectation depends on build)
        do_op(32'hFFFF_FFFD, 32'd7, 1'b1, p, cyc);
`ifdef MULFUNC_SIGNED_EN
        exp64 = 64'hFFFF_FFFF_FFFF_FFEB;
`else
        exp64 = 64'h0000_0006_FFFF_FFEB;
`endif
        chk("sgn_prod", p, exp64);
        chk("sgn_lat", 64'(cyc), 64'd9);
        tick();

        // Random, stops at the first mismatch
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i >= 100) rb = rb & 32'h0000_00FF;
            do_op(ra, rb, 1'b0, p, cyc);
            chk("rand", p, {32'd0, ra} * {32'd0, rb});
            tick();
            if (errors != 0) break;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
